// File: rtl/ctx_lps_pipe.sv
// Context probability bank with a three-stage LPS range lookup pipeline.
// Dual-window states adapt on decoded bins; each request snapshots its context at accept.
module ctx_lps_pipe #(
    parameter int NUM_CTX   = 64,
    parameter int CTX_AW    = 6,
    parameter int DEF_RATE0 = 4,
    parameter int DEF_RATE1 = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CTX_AW-1:0] req_ctx,
    input  logic [8:0]        req_range,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_lps,
    output logic              rsp_mps,
    input  logic              upd_valid,
    input  logic [CTX_AW-1:0] upd_ctx,
    input  logic              upd_bin,
    input  logic              init_valid,
    input  logic [CTX_AW-1:0] init_ctx,
    input  logic [14:0]       init_prob,
    input  logic [2:0]        init_rate0,
    input  logic [2:0]        init_rate1
);

    localparam logic [CTX_AW:0] NUM_CTX_W = (CTX_AW+1)'(NUM_CTX);
    localparam logic [14:0]     PROB_HALF = 15'd16384;
    localparam logic [2:0]      RATE0_RST = 3'(DEF_RATE0);
    localparam logic [2:0]      RATE1_RST = 3'(DEF_RATE1);

    function automatic logic [14:0] adapt(input logic [14:0] s, input logic [2:0] rate,
                                          input logic bin);
        logic [15:0] s16;
        logic [15:0] delta;
        s16 = {1'b0, s};
        delta = bin ? ((16'd32768 - s16) >> rate) : (s16 >> rate);
        return bin ? 15'(s16 + delta) : 15'(s16 - delta);
    endfunction

    function automatic logic [2:0] fix_rate(input logic [2:0] r);
        return (r == 3'd0) ? 3'd1 : r;
    endfunction

    function automatic logic [7:0] lps_of(input logic [5:0] qd, input logic [3:0] rs);
        logic [9:0] prod;
        prod = 10'(qd) * 10'(rs);
        return 8'((prod >> 1) + 10'd4);
    endfunction

    logic [14:0] s0_mem [NUM_CTX];
    logic [14:0] s1_mem [NUM_CTX];
    logic [2:0]  r0_mem [NUM_CTX];
    logic [2:0]  r1_mem [NUM_CTX];

    logic              init_ok, upd_ok, req_in;
    logic [CTX_AW-1:0] upd_idx, req_idx;
    logic [14:0]       upd_s0, upd_s1, rd_s0, rd_s1;
    logic [15:0]       sum_s0;
    logic              stall;

    assign init_ok = init_valid && ({1'b0, init_ctx} < NUM_CTX_W);
    assign upd_ok  = upd_valid && ({1'b0, upd_ctx} < NUM_CTX_W) &&
                     !(init_ok && (init_ctx == upd_ctx));
    assign req_in  = {1'b0, req_ctx} < NUM_CTX_W;
    assign upd_idx = upd_ok ? upd_ctx : '0;
    assign req_idx = req_in ? req_ctx : '0;

    assign upd_s0 = adapt(s0_mem[upd_idx], r0_mem[upd_idx], upd_bin);
    assign upd_s1 = adapt(s1_mem[upd_idx], r1_mem[upd_idx], upd_bin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                s0_mem[i] <= PROB_HALF;
                s1_mem[i] <= PROB_HALF;
                r0_mem[i] <= RATE0_RST;
                r1_mem[i] <= RATE1_RST;
            end
        end else begin
            if (upd_ok) begin
                s0_mem[upd_idx] <= upd_s0;
                s1_mem[upd_idx] <= upd_s1;
            end
            if (init_ok) begin
                s0_mem[init_ctx] <= init_prob;
                s1_mem[init_ctx] <= init_prob;
                r0_mem[init_ctx] <= fix_rate(init_rate0);
                r1_mem[init_ctx] <= fix_rate(init_rate1);
            end
        end
    end

    // Stage S0: read with same-cycle write bypass; out-of-range contexts read as equiprobable
    always_comb begin
        rd_s0 = PROB_HALF;
        rd_s1 = PROB_HALF;
        if (req_in) begin
            if (init_ok && (init_ctx == req_ctx)) begin
                rd_s0 = init_prob;
                rd_s1 = init_prob;
            end else if (upd_ok && (upd_ctx == req_ctx)) begin
                rd_s0 = upd_s0;
                rd_s1 = upd_s1;
            end else begin
                rd_s0 = s0_mem[req_idx];
                rd_s1 = s1_mem[req_idx];
            end
        end
    end

    assign sum_s0    = {1'b0, rd_s0} + {1'b0, rd_s1};
    assign stall     = rsp_valid && !rsp_ready;
    assign req_ready = !stall;

    logic [7:0] st_p0;
    logic [8:0] range_p0;
    logic [7:0] q_s1;
    logic [5:0] qd_p1;
    logic [3:0] rs_p1;
    logic       mps_p1;
    logic       vld_p0, vld_p1;

    always_ff @(posedge clk) begin
        if (!stall) begin
            st_p0    <= sum_s0[15:8];
            range_p0 <= req_range;
        end
    end

    // Stage S1: fold the state onto the LPS side and quantise
    assign q_s1 = st_p0[7] ? (st_p0 ^ 8'hFF) : st_p0;

    always_ff @(posedge clk) begin
        if (!stall) begin
            qd_p1  <= q_s1[7:2];
            rs_p1  <= range_p0[8:5];
            mps_p1 <= st_p0[7];
        end
    end

    // Stage S2: product into the output registers; the whole pipe freezes on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_lps   <= '0;
            rsp_mps   <= 1'b0;
        end else if (!stall) begin
            vld_p0    <= req_valid;
            vld_p1    <= vld_p0;
            rsp_valid <= vld_p1;
            if (vld_p1) begin
                rsp_lps <= lps_of(qd_p1, rs_p1);
                rsp_mps <= mps_p1;
            end
        end
    end

endmodule

// File: tb/tb_ctx_lps_pipe.sv
// Randomised bench for ctx_lps_pipe against an arithmetic context model and a response queue.
// NUM_CTX is set below 2^CTX_AW so out-of-range context handling is exercised.
module tb_ctx_lps_pipe;

    localparam int NUM_CTX = 48;
    localparam int CTX_AW  = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [CTX_AW-1:0] req_ctx;
    logic [8:0]        req_range;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_lps;
    logic              rsp_mps;
    logic              upd_valid;
    logic [CTX_AW-1:0] upd_ctx;
    logic              upd_bin;
    logic              init_valid;
    logic [CTX_AW-1:0] init_ctx;
    logic [14:0]       init_prob;
    logic [2:0]        init_rate0;
    logic [2:0]        init_rate1;

    ctx_lps_pipe #(.NUM_CTX(NUM_CTX), .CTX_AW(CTX_AW), .DEF_RATE0(4), .DEF_RATE1(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_ctx(req_ctx), .req_range(req_range),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lps(rsp_lps), .rsp_mps(rsp_mps),
        .upd_valid(upd_valid), .upd_ctx(upd_ctx), .upd_bin(upd_bin),
        .init_valid(init_valid), .init_ctx(init_ctx), .init_prob(init_prob),
        .init_rate0(init_rate0), .init_rate1(init_rate1)
    );

    always #5 clk = ~clk;

    typedef struct { int lps; int mps; } exp_t;
    exp_t exp_q[$];

    int m_s0 [NUM_CTX];
    int m_s1 [NUM_CTX];
    int m_r0 [NUM_CTX];
    int m_r1 [NUM_CTX];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_CTX; i++) begin
            m_s0[i] = 16384; m_s1[i] = 16384; m_r0[i] = 4; m_r1[i] = 7;
        end
    endfunction

    function automatic int model_adapt(input int s, input int r, input bit b);
        return b ? s + ((32768 - s) >> r) : s - (s >> r);
    endfunction

    function automatic void model_write(input bit uv, input int uc, input bit ub, input bit iv,
                                        input int ic, input int ip, input int ir0, input int ir1);
        if (uv && uc < NUM_CTX && !(iv && ic == uc)) begin
            m_s0[uc] = model_adapt(m_s0[uc], m_r0[uc], ub);
            m_s1[uc] = model_adapt(m_s1[uc], m_r1[uc], ub);
        end
        if (iv && ic < NUM_CTX) begin
            m_s0[ic] = ip; m_s1[ic] = ip;
            m_r0[ic] = (ir0 == 0) ? 1 : ir0;
            m_r1[ic] = (ir1 == 0) ? 1 : ir1;
        end
    endfunction

    function automatic void model_rsp(input int c, input int rng, output int lps, output int mps);
        int a, b, st, q;
        a = (c < NUM_CTX) ? m_s0[c] : 16384;
        b = (c < NUM_CTX) ? m_s1[c] : 16384;
        st  = (a + b) / 256;
        mps = (st >= 128) ? 1 : 0;
        q   = mps ? 255 - st : st;
        lps = (((q / 4) * (rng / 32)) / 2 + 4) % 256;
    endfunction

    // One clock cycle: drive at the falling edge, score the response, advance the model.
    task automatic step(input bit rv, input int rc, input int rr, input bit uv, input int uc,
                        input bit ub, input bit iv, input int ic, input int ip, input int ir0,
                        input int ir1, input bit rdy, input bit fixed, input int f_lps,
                        input int f_mps, output bit acc);
        exp_t e;
        req_valid  = rv;  req_ctx = CTX_AW'(rc); req_range = 9'(rr);
        upd_valid  = uv;  upd_ctx = CTX_AW'(uc); upd_bin = ub;
        init_valid = iv;  init_ctx = CTX_AW'(ic); init_prob = 15'(ip);
        init_rate0 = 3'(ir0); init_rate1 = 3'(ir1);
        rsp_ready  = rdy;
        #1;
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_rsp", 1, 0);
            end else begin
                check_val("rsp_lps", int'(rsp_lps), exp_q[0].lps);
                check_val("rsp_mps", int'(rsp_mps), exp_q[0].mps);
                if (rdy) void'(exp_q.pop_front());
            end
        end
        acc = rv && req_ready;
        model_write(uv, uc, ub, iv, ic, ip, ir0, ir1);
        if (acc) begin
            if (fixed) begin
                e.lps = f_lps; e.mps = f_mps;
            end else begin
                model_rsp(rc, rr, e.lps, e.mps);
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 256, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, a);
    endtask

    initial begin
        bit acc;
        bit saw_stall;
        int sent, cyc;
        int rc, uc, ic;

        rst_n = 1'b0;
        req_valid = 0; req_ctx = '0; req_range = 9'd256; rsp_ready = 1;
        upd_valid = 0; upd_ctx = '0; upd_bin = 0;
        init_valid = 0; init_ctx = '0; init_prob = '0; init_rate0 = '0; init_rate1 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rst_req_ready", int'(req_ready), 1);
        check_val("rst_rsp_valid", int'(rsp_valid), 0);
        check_val("rst_rsp_lps", int'(rsp_lps), 0);
        check_val("rst_rsp_mps", int'(rsp_mps), 0);

        // Latency: one request, response visible in the third cycle after acceptance
        req_valid = 1; req_ctx = '0; req_range = 9'd510; rsp_ready = 1;
        @(posedge clk); @(negedge clk);
        req_valid = 0;
        check_val("lat_cyc1", int'(rsp_valid), 0);
        @(posedge clk); @(negedge clk);
        check_val("lat_cyc2", int'(rsp_valid), 0);
        @(posedge clk); @(negedge clk);
        check_val("lat_cyc3", int'(rsp_valid), 1);
        check_val("lat_lps", int'(rsp_lps), 236);
        check_val("lat_mps", int'(rsp_mps), 1);
        @(posedge clk); @(negedge clk);
        check_val("lat_consumed", int'(rsp_valid), 0);

        // Single-update cases from the reset state, then same-cycle bypass and init priority
        step(0, 0, 256, 1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, acc);
        step(1, 5, 510, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 229, 1, acc);
        step(0, 0, 256, 1, 6, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, acc);
        step(1, 6, 510, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 229, 0, acc);
        step(1, 3, 510, 1, 3, 1, 0, 0, 0, 0, 0, 1, 1, 229, 1, acc);
        step(1, 3, 510, 1, 3, 1, 1, 3, 0, 4, 7, 1, 1, 4, 0, acc);
        step(1, 50, 510, 1, 50, 0, 1, 50, 0, 2, 2, 1, 1, 236, 1, acc);
        step(1, 47, 510, 0, 0, 0, 1, 47, 0, 0, 0, 1, 1, 4, 0, acc);
        idle(5);
        check_val("directed_drained", exp_q.size(), 0);

        // Backpressure: five back-to-back requests with the consumer stalled mid-stream
        sent = 0; cyc = 0; saw_stall = 0;
        while (sent < 5 && cyc < 40) begin
            step(1, 10 + sent, 256 + sent * 60, 0, 0, 0, 0, 0, 0, 0, 0,
                 !(cyc >= 2 && cyc < 6), 0, 0, 0, acc);
            if (acc) sent++;
            else saw_stall = 1;
            cyc++;
        end
        check_val("bp_all_sent", sent, 5);
        check_val("bp_ready_dropped", int'(saw_stall), 1);
        idle(6);
        check_val("bp_drained", exp_q.size(), 0);

        // Random traffic with concurrent updates, inits and consumer stalls
        for (int n = 0; n < 3000; n++) begin
            rc = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 63);
            uc = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 63);
            ic = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 63);
            step($urandom_range(0, 9) < 7, rc, $urandom_range(256, 510),
                 $urandom_range(0, 1), uc, $urandom_range(0, 1),
                 $urandom_range(0, 9) == 0, ic, $urandom_range(0, 32767),
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, 0, 0, 0, acc);
        end
        idle(8);
        check_val("rand_drained", exp_q.size(), 0);

        // Asynchronous reset with requests in flight
        step(1, 5, 400, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, acc);
        step(1, 3, 450, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, acc);
        step(1, 47, 510, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, acc);
        req_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_rsp_valid", int'(rsp_valid), 0);
        check_val("arst_rsp_lps", int'(rsp_lps), 0);
        check_val("arst_req_ready", int'(req_ready), 1);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        step(1, 5, 510, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 236, 1, acc);
        step(1, 3, 510, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 236, 1, acc);
        step(1, 47, 510, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 236, 1, acc);
        step(1, 0, 510, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 236, 1, acc);
        idle(6);
        check_val("arst_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ctx_lps_pipe.md
Name: ctx_lps_pipe

Overview:
- Parametrised successor to the combinational LPS-range lookup in the arithmetic decoder.
- Holds a bank of NUM_CTX dual-window context probability states (VVC style, two 15-bit estimates with per-context adaptation rates).
- Serves pipelined LPS/MPS requests through a valid/ready handshake and applies bin-driven probability updates.
- Sits between the bin-decode control FSM and the range/offset renormalisation logic.

Parameters:
- NUM_CTX, 64, number of contexts held.
- CTX_AW, 6, context index width; must satisfy 2^CTX_AW >= NUM_CTX.
- DEF_RATE0, 4, window-0 shift rate loaded at reset, 1..7.
- DEF_RATE1, 7, window-1 shift rate loaded at reset, 1..7.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  lookup request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_ctx  in  CTX_AW  context index.
- req_range  in  9  current decoder range, 256..510.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer ready.
- rsp_lps  out  8  LPS range.
- rsp_mps  out  1  MPS value.
- upd_valid  in  1  apply bin update.
- upd_ctx  in  CTX_AW  context to update.
- upd_bin  in  1  decoded bin.
- init_valid  in  1  overwrite one context.
- init_ctx  in  CTX_AW  context to initialise.
- init_prob  in  15  value written to both s0 and s1.
- init_rate0  in  3  window-0 rate.
- init_rate1  in  3  window-1 rate.

Behaviour:
- Reset (async, rst_n=0):
  - Every context gets s0 = s1 = 16384, rate0 = DEF_RATE0, rate1 = DEF_RATE1.
  - Pipeline valids cleared; rsp_valid = 0, rsp_lps = 0, rsp_mps = 0.
  - req_ready = 1 after reset release.
  - Reset mid-operation discards all in-flight requests.
- Storage: flop array, one s0[15], s1[15], rate0[3], rate1[3] per context. An init rate of 0 is stored as 1.
- Update rule when upd_valid:
  - bin=1: s += (32768 - s) >> rate.
  - bin=0: s -= s >> rate.
  - Applied to s0 with rate0 and to s1 with rate1, computed in 16 bits and written at the clock edge.
  - Result is always within 0..32767, so no saturation logic is needed.
- Write priority for the same context in the same cycle: init over upd.
- upd_ctx or init_ctx >= NUM_CTX: ignored.
- Pipeline stage S0 (accept cycle):
  - Read the context state.
  - Bypass: if upd or init targets req_ctx in the same cycle, S0 uses the post-write value.
  - st = (s0 + s1) >> 8, 8-bit. Register st and req_range.
  - req_ctx >= NUM_CTX: the request still completes and reads a state of 16384/16384.
- Stage S1:
  - mps = st[7]; q = st[7] ? st ^ 8'hFF : st.
  - Register (q >> 2) as 6 bits, (range >> 5) as 4 bits, and mps.
- Stage S2:
  - lps = (((q >> 2) * (range >> 5)) >> 1) + 4, computed as a 10-bit product, truncated to 8 bits.
  - Output registers hold the result; rsp_valid is asserted.
- Latency: response appears 3 cycles after acceptance when rsp_ready is held high. Throughput is 1 request per cycle.
- Backpressure:
  - Whole-pipe stall; req_ready = !(rsp_valid && !rsp_ready).
  - During a stall all stage registers hold and rsp_* stay stable.
  - Bubbles do not collapse.
- Ordering: responses return in request order.
- Updates are independent of the pipeline and accepted every cycle, including during stalls. A request already past S0 is unaffected by later updates (snapshot at accept).

Test Plan:
- Reset, then request ctx 0 with range 510 and rsp_ready=1 -> 3 cycles later rsp_valid=1, lps=236, mps=1.
- After reset, upd ctx 5 with bin=1, then request ctx 5 with range 510 -> s0=17408, s1=16512, st=132, lps=229, mps=1.
- After reset, upd ctx 5 with bin=0, then request ctx 5 with range 510 -> s0=15360, s1=16256, st=123, lps=229, mps=0.
- Same-cycle bypass: upd ctx 3 bin=1 together with a req on ctx 3 -> response reflects the updated state (lps=229). Same-cycle init ctx 3 with prob 0 plus upd -> init wins, s0=s1=0, st=0, lps=4, mps=0.
- Backpressure: 5 back-to-back requests with rsp_ready low for 4 cycles mid-stream -> req_ready drops, no response is lost or duplicated, order is preserved, outputs stay stable while stalled.
- Async reset asserted with 3 requests in flight -> rsp_valid=0 immediately; all contexts read 16384 afterwards; no stale response appears.
